// File: rtl/shift_sequencer_if.sv
// Handshake and serial-chain signals between a parallel requester and shift_sequencer.
interface shift_sequencer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             valid_in;
    logic             ready_out;
    logic             so;
    logic             si;
    logic             shift_en;
    logic             busy;
    logic [WIDTH-1:0] data_out;
    logic             valid_out;

    modport master (
        output data_in, valid_in, si,
        input  ready_out, so, shift_en, busy, data_out, valid_out
    );

    modport slave (
        input  data_in, valid_in, si,
        output ready_out, so, shift_en, busy, data_out, valid_out
    );
endinterface

// File: rtl/shift_sequencer.sv
// Full-duplex serial shift controller: shifts a word out MSB-first on so while
// capturing si into the same register, one bit every DIV clocks.
module shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int DIV   = 1
) (
    input  logic            clk,
    input  logic            reset,
    shift_sequencer_if.slave bus
);
    localparam int BIT_W = $clog2(WIDTH + 1);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] shreg, shreg_next;
    logic [WIDTH-1:0] data_out_q, data_out_next;
    logic [BIT_W-1:0] bitcnt, bitcnt_next;
    logic [DIV_W-1:0] divcnt, divcnt_next;
    logic             valid_out_q, valid_out_next;
    logic             shift_edge;
    logic             last_bit;

    assign shift_edge = (state == SHIFT) && (divcnt == DIV_W'(DIV - 1));
    assign last_bit   = (bitcnt == BIT_W'(WIDTH - 1));

    // Every output is a decode of registered state, never of an input.
    assign bus.ready_out = (state == IDLE);
    assign bus.busy      = (state == SHIFT);
    assign bus.so        = (state == SHIFT) & shreg[WIDTH-1];
    assign bus.shift_en  = shift_edge;
    assign bus.data_out  = data_out_q;
    assign bus.valid_out = valid_out_q;

    always_comb begin
        state_next     = state;
        shreg_next     = shreg;
        data_out_next  = data_out_q;
        bitcnt_next    = bitcnt;
        divcnt_next    = divcnt;
        valid_out_next = 1'b0;
        case (state)
            IDLE: begin
                if (bus.valid_in) begin
                    shreg_next  = bus.data_in;
                    bitcnt_next = '0;
                    divcnt_next = '0;
                    state_next  = SHIFT;
                end
            end
            SHIFT: begin
                divcnt_next = shift_edge ? '0 : divcnt + DIV_W'(1);
                if (shift_edge) begin
                    shreg_next = {shreg[WIDTH-2:0], bus.si};
                    if (last_bit) begin
                        data_out_next  = {shreg[WIDTH-2:0], bus.si};
                        valid_out_next = 1'b1;
                        bitcnt_next    = '0;
                        state_next     = IDLE;
                    end else begin
                        bitcnt_next = bitcnt + BIT_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            shreg       <= '0;
            data_out_q  <= '0;
            bitcnt      <= '0;
            divcnt      <= '0;
            valid_out_q <= 1'b0;
        end else begin
            state       <= state_next;
            shreg       <= shreg_next;
            data_out_q  <= data_out_next;
            bitcnt      <= bitcnt_next;
            divcnt      <= divcnt_next;
            valid_out_q <= valid_out_next;
        end
    end
endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: one DIV=1 and one DIV=3 instance, checked against a
// timing/bit-order model derived from the accept edge.
module tb_shift_sequencer;
    localparam int W = 8;
    localparam logic [1:0] MODE_ZERO  = 2'd0;
    localparam logic [1:0] MODE_RAND  = 2'd1;
    localparam logic [1:0] MODE_LOOP  = 2'd2;
    localparam logic [1:0] MODE_CHAIN = 2'd3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    shift_sequencer_if #(.WIDTH(W)) b1 ();
    shift_sequencer_if #(.WIDTH(W)) b3 ();

    shift_sequencer #(.WIDTH(W), .DIV(1)) dut1 (.clk(clk), .reset(reset), .bus(b1.slave));
    shift_sequencer #(.WIDTH(W), .DIV(3)) dut3 (.clk(clk), .reset(reset), .bus(b3.slave));

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0]   si_mode;
    logic         si_rnd;
    logic [W-1:0] chain;
    logic [W-1:0] chain_val;
    logic         chain_load;
    logic [W-1:0] prev_dout [2];

    assign b1.si = (si_mode == MODE_LOOP) ? b1.so : (si_mode == MODE_CHAIN) ? chain[W-1] : si_rnd;
    assign b3.si = (si_mode == MODE_LOOP) ? b3.so : si_rnd;

    // External serial-in/serial-out chain advanced by the DUT's shift strobe.
    always @(posedge clk) begin
        if (chain_load) chain <= chain_val;
        else if (b1.shift_en) chain <= {chain[W-2:0], b1.so};
    end

    task automatic drive(input bit sel, input logic v, input logic [W-1:0] d);
        if (sel) begin b3.valid_in = v; b3.data_in = d; end
        else begin b1.valid_in = v; b1.data_in = d; end
    endtask

    // Call at a negedge; offers word, follows it to completion, leaves the bench at the
    // negedge of the VALID_OUT cycle with next_valid/next_word presented.
    task automatic run_txn(input bit sel, input logic [W-1:0] word, input logic [W-1:0] chain_pre,
                           input bit hold_valid, input bit next_valid, input logic [W-1:0] next_word,
                           input string tag);
        int div = sel ? 3 : 1;
        int n   = W * div;
        logic [W-1:0] exp_word = '0;
        logic [W-1:0] dout, e_dout;
        logic rdy, bsy, so, sen, vo, e_rdy, e_bsy, e_so, e_sen, e_vo;
        drive(sel, 1'b1, word);
        rdy = sel ? b3.ready_out : b1.ready_out;
        n_checks++;
        if (rdy !== 1'b1) begin n_fail++; $display("[TB] FAIL %s accept_ready: got %b want 1", tag, rdy); end
        for (int c = 1; c <= n + 1; c++) begin
            @(negedge clk);
            rdy  = sel ? b3.ready_out : b1.ready_out;
            bsy  = sel ? b3.busy      : b1.busy;
            so   = sel ? b3.so        : b1.so;
            sen  = sel ? b3.shift_en  : b1.shift_en;
            vo   = sel ? b3.valid_out : b1.valid_out;
            dout = sel ? b3.data_out  : b1.data_out;
            if (c <= n) begin
                e_rdy = 1'b0; e_bsy = 1'b1; e_vo = 1'b0;
                e_so  = word[W-1-(c-1)/div];
                e_sen = ((c % div) == 0);
                e_dout = prev_dout[sel];
            end else begin
                e_rdy = 1'b1; e_bsy = 1'b0; e_vo = 1'b1; e_so = 1'b0; e_sen = 1'b0;
                case (si_mode)
                    MODE_LOOP:  e_dout = word;
                    MODE_CHAIN: e_dout = chain_pre;
                    default:    e_dout = exp_word;
                endcase
                prev_dout[sel] = e_dout;
            end
            n_checks++;
            if (rdy !== e_rdy) begin n_fail++; $display("[TB] FAIL %s ready_out c%0d: got %b want %b", tag, c, rdy, e_rdy); end
            n_checks++;
            if (bsy !== e_bsy) begin n_fail++; $display("[TB] FAIL %s busy c%0d: got %b want %b", tag, c, bsy, e_bsy); end
            n_checks++;
            if (so !== e_so) begin n_fail++; $display("[TB] FAIL %s so c%0d: got %b want %b", tag, c, so, e_so); end
            n_checks++;
            if (sen !== e_sen) begin n_fail++; $display("[TB] FAIL %s shift_en c%0d: got %b want %b", tag, c, sen, e_sen); end
            n_checks++;
            if (vo !== e_vo) begin n_fail++; $display("[TB] FAIL %s valid_out c%0d: got %b want %b", tag, c, vo, e_vo); end
            n_checks++;
            if (dout !== e_dout) begin n_fail++; $display("[TB] FAIL %s data_out c%0d: got %h want %h", tag, c, dout, e_dout); end
            if (c <= n) begin
                if (si_mode == MODE_RAND) si_rnd = 1'($urandom);
                else si_rnd = 1'b0;
                if ((c % div) == 0) exp_word = {exp_word[W-2:0], si_rnd};
                drive(sel, hold_valid, 8'($urandom));
            end else begin
                drive(sel, next_valid, next_word);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(0, 1'b0, '0);
        drive(1, 1'b0, '0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        prev_dout[0] = '0;
        prev_dout[1] = '0;
        for (int c = 0; c < 20; c++) begin
            drive(0, 1'b0, 8'($urandom));
            drive(1, 1'b0, 8'($urandom));
            @(negedge clk);
            n_checks++;
            if ({b1.ready_out, b1.busy, b1.so, b1.shift_en, b1.valid_out} !== 5'b10000) begin
                n_fail++; $display("[TB] FAIL reset_idle_div1 c%0d: got %b want 10000", c, {b1.ready_out, b1.busy, b1.so, b1.shift_en, b1.valid_out});
            end
            n_checks++;
            if ({b3.ready_out, b3.busy, b3.so, b3.shift_en, b3.valid_out} !== 5'b10000) begin
                n_fail++; $display("[TB] FAIL reset_idle_div3 c%0d: got %b want 10000", c, {b3.ready_out, b3.busy, b3.so, b3.shift_en, b3.valid_out});
            end
            n_checks++;
            if (b1.data_out !== 8'h00 || b3.data_out !== 8'h00) begin
                n_fail++; $display("[TB] FAIL reset_data_out c%0d: got %h/%h want 00/00", c, b1.data_out, b3.data_out);
            end
        end
    endtask

    task automatic test_loopback();
        si_mode = MODE_LOOP;
        run_txn(0, 8'hA5, '0, 0, 0, '0, "loopback_a5");
        @(negedge clk);
    endtask

    task automatic test_chain();
        chain_val  = 8'h3C;
        chain_load = 1'b1;
        @(negedge clk);
        chain_load = 1'b0;
        si_mode    = MODE_CHAIN;
        run_txn(0, 8'hFF, 8'h3C, 0, 0, '0, "chain_ff");
        n_checks++;
        if (chain !== 8'hFF) begin n_fail++; $display("[TB] FAIL chain_contents: got %h want ff", chain); end
        @(negedge clk);
    endtask

    task automatic test_div3();
        si_mode = MODE_ZERO;
        si_rnd  = 1'b0;
        run_txn(1, 8'h81, '0, 0, 0, '0, "div3_81");
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] w1, w2;
        si_mode = MODE_RAND;
        for (int s = 0; s < 2; s++) begin
            w1 = 8'($urandom);
            w2 = 8'($urandom);
            run_txn(s[0], w1, '0, 1, 1, w2, "b2b_first");
            run_txn(s[0], w2, '0, 0, 0, '0, "b2b_second");
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        logic [1:0] m;
        for (int i = 0; i < 8; i++) begin
            m = 2'($urandom_range(0, 2));
            si_mode = m;
            run_txn(1'($urandom), 8'($urandom), '0, 1'($urandom), 0, '0, "random");
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        si_mode = MODE_LOOP;
        drive(0, 1'b1, 8'hF0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            drive(0, 1'b0, 8'($urandom));
        end
        n_checks++;
        if (b1.busy !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_mid_busy_before: got %b want 1", b1.busy); end
        reset = 1'b1;
        drive(0, 1'b1, 8'h55);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 1'b0, '0);
        prev_dout[0] = '0;
        prev_dout[1] = '0;
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if ({b1.ready_out, b1.busy, b1.so, b1.shift_en, b1.valid_out} !== 5'b10000) begin
                n_fail++; $display("[TB] FAIL reset_mid_idle c%0d: got %b want 10000", c, {b1.ready_out, b1.busy, b1.so, b1.shift_en, b1.valid_out});
            end
            n_checks++;
            if (b1.data_out !== 8'h00 || b3.data_out !== 8'h00) begin
                n_fail++; $display("[TB] FAIL reset_mid_data_out c%0d: got %h/%h want 00/00", c, b1.data_out, b3.data_out);
            end
            @(negedge clk);
        end
        run_txn(0, 8'h0F, '0, 0, 0, '0, "after_reset_0f");
        @(negedge clk);
    endtask

    initial begin
        reset      = 1'b1;
        si_mode    = MODE_ZERO;
        si_rnd     = 1'b0;
        chain_val  = '0;
        chain_load = 1'b1;
        drive(0, 1'b0, '0);
        drive(1, 1'b0, '0);
        @(negedge clk);
        chain_load = 1'b0;
        test_reset();
        test_loopback();
        test_chain();
        test_div3();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
